// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the pooled feature-map buffer:
//   - default pooled-map dimensions and pixel width
//   - channel count of the pooled map
//   - FILL/DRAIN state encoding used by pool_fmap_buffer
// ---------------------------------------------------------------------------
package cnn_pkg;

   localparam int CONV_BIT       = 12;  // width of one pooled pixel
   localparam int HALF_WIDTH     = 12;  // pooled map width
   localparam int HALF_HEIGHT    = 12;  // pooled map height
   localparam int HALF_WIDTH_BIT = 4;   // row / column index width
   localparam int NUM_CH         = 3;   // channels stored side by side per address

   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_DRAIN = 1'b1
   } buf_state_t;

endpackage

// File: rtl/fmap_ram.sv
// ---------------------------------------------------------------------------
// fmap_ram
// Simple dual-port RAM, one write port and one registered read port, written
// so that synthesis maps it onto block RAM. Contents are not reset.
// Ports:
//   clk      : clock, rising edge
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe; rd_data updates on the edge where it is high
//   rd_addr  : read address
//   rd_data  : registered read data (valid the cycle after rd_en)
// ---------------------------------------------------------------------------
module fmap_ram #(
   parameter int DATA_BIT = 36,
   parameter int DEPTH    = 144,
   parameter int ADDR_BIT = 8
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic [ADDR_BIT-1:0] wr_addr,
   input  logic [DATA_BIT-1:0] wr_data,
   input  logic                rd_en,
   input  logic [ADDR_BIT-1:0] rd_addr,
   output logic [DATA_BIT-1:0] rd_data
);

   logic [DATA_BIT-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/pool_fmap_buffer.sv
// ---------------------------------------------------------------------------
// pool_fmap_buffer
// Collects one pooled feature map (three channels per pixel, raster order) and
// then streams it out channel-major with a valid/ready handshake.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   valid_in     : qualifies max_value_1..3 (accepted only while filling)
//   max_value_1..3 : pooled pixel of channels 0..2
//   data_out     : drained pixel
//   valid_out    : data_out / ch_idx / row_idx / col_idx are valid
//   ready_in     : downstream accepts data (ignored while filling)
//   ch_idx       : channel of data_out (0..2)
//   row_idx      : row of data_out
//   col_idx      : column of data_out
//   frame_done   : one-cycle pulse after the last pixel has been transferred
//   overflow     : sticky, set when an input pixel arrives while draining
// ---------------------------------------------------------------------------
module pool_fmap_buffer #(
   parameter int CONV_BIT       = cnn_pkg::CONV_BIT,
   parameter int HALF_WIDTH     = cnn_pkg::HALF_WIDTH,
   parameter int HALF_HEIGHT    = cnn_pkg::HALF_HEIGHT,
   parameter int HALF_WIDTH_BIT = cnn_pkg::HALF_WIDTH_BIT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      valid_in,
   input  logic [CONV_BIT-1:0]       max_value_1,
   input  logic [CONV_BIT-1:0]       max_value_2,
   input  logic [CONV_BIT-1:0]       max_value_3,
   output logic [CONV_BIT-1:0]       data_out,
   output logic                      valid_out,
   input  logic                      ready_in,
   output logic [1:0]                ch_idx,
   output logic [HALF_WIDTH_BIT-1:0] row_idx,
   output logic [HALF_WIDTH_BIT-1:0] col_idx,
   output logic                      frame_done,
   output logic                      overflow
);
   import cnn_pkg::*;

   localparam int DEPTH    = HALF_WIDTH * HALF_HEIGHT;
   localparam int ADDR_BIT = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [HALF_WIDTH_BIT-1:0] COL_LAST = HALF_WIDTH_BIT'(HALF_WIDTH - 1);
   localparam logic [HALF_WIDTH_BIT-1:0] ROW_LAST = HALF_WIDTH_BIT'(HALF_HEIGHT - 1);
   localparam logic [1:0]                CH_LAST  = 2'(NUM_CH - 1);

   buf_state_t state_reg, state_next;

   // write side
   logic [HALF_WIDTH_BIT-1:0] wr_row_reg, wr_col_reg;
   logic                      wr_fire, wr_last;
   logic [ADDR_BIT-1:0]       wr_addr;
   logic [NUM_CH*CONV_BIT-1:0] wr_data;

   // read issue counters (address of the next RAM read)
   logic [1:0]                rd_ch_reg;
   logic [HALF_WIDTH_BIT-1:0] rd_row_reg, rd_col_reg;
   logic                      issue_done_reg;
   logic [ADDR_BIT-1:0]       rd_addr;
   logic [NUM_CH*CONV_BIT-1:0] rd_data;
   logic [CONV_BIT-1:0]       rd_lane [NUM_CH];

   // RAM output stage: pixel whose read was issued on the previous edge
   logic                      pend_valid_reg;
   logic [1:0]                pend_ch_reg;
   logic [HALF_WIDTH_BIT-1:0] pend_row_reg, pend_col_reg;
   logic [CONV_BIT-1:0]       pend_pix;

   // skid entry: catches the in-flight read when the output stalls
   logic                      skid_valid_reg;
   logic [CONV_BIT-1:0]       skid_data_reg;
   logic [1:0]                skid_ch_reg;
   logic [HALF_WIDTH_BIT-1:0] skid_row_reg, skid_col_reg;

   // output register
   logic                      out_valid_reg;
   logic [CONV_BIT-1:0]       out_data_reg;
   logic [1:0]                out_ch_reg;
   logic [HALF_WIDTH_BIT-1:0] out_row_reg, out_col_reg;
   logic                      frame_done_reg, overflow_reg;

   logic       pop, out_last, frame_end, load_out, skid_load, issue;
   logic [1:0] occ, occ_after;

   assign wr_fire = (state_reg == ST_FILL) && valid_in && !rst;
   assign wr_last = wr_fire && (wr_row_reg == ROW_LAST) && (wr_col_reg == COL_LAST);
   assign wr_addr = ADDR_BIT'(int'(wr_row_reg) * HALF_WIDTH + int'(wr_col_reg));
   assign wr_data = {max_value_3, max_value_2, max_value_1};
   assign rd_addr = ADDR_BIT'(int'(rd_row_reg) * HALF_WIDTH + int'(rd_col_reg));

   assign pop       = out_valid_reg && ready_in;
   assign out_last  = (out_ch_reg == CH_LAST) && (out_row_reg == ROW_LAST) && (out_col_reg == COL_LAST);
   assign frame_end = pop && out_last;
   assign load_out  = !out_valid_reg || pop;

   // Reads are issued on credit: output register plus skid give two slots, so
   // a read may launch whenever at most one slot stays occupied after this edge.
   assign occ       = 2'(out_valid_reg) + 2'(skid_valid_reg) + 2'(pend_valid_reg);
   assign occ_after = occ - 2'(pop);
   assign issue     = (state_reg == ST_DRAIN) && !issue_done_reg && (occ_after < 2'd2);

   // A stalled output with a full skid never coexists with a pending read,
   // so the pending pixel goes to skid whenever the output does not take it.
   assign skid_load = pend_valid_reg && (skid_valid_reg ? load_out : !load_out);

   fmap_ram #(
      .DATA_BIT (NUM_CH * CONV_BIT),
      .DEPTH    (DEPTH),
      .ADDR_BIT (ADDR_BIT)
   ) u_fmap_ram (
      .clk     (clk),
      .wr_en   (wr_fire),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (issue),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
         assign rd_lane[gi] = rd_data[gi*CONV_BIT +: CONV_BIT];
      end
   endgenerate

   always_comb begin
      pend_pix = rd_lane[0];
      case (pend_ch_reg)
         2'd1:    pend_pix = rd_lane[1];
         2'd2:    pend_pix = rd_lane[2];
         default: pend_pix = rd_lane[0];
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_FILL:  if (wr_last)   state_next = ST_DRAIN;
         ST_DRAIN: if (frame_end) state_next = ST_FILL;
         default:  state_next = ST_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_reg <= ST_FILL;
      else     state_reg <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_row_reg     <= '0;
         wr_col_reg     <= '0;
         rd_ch_reg      <= '0;
         rd_row_reg     <= '0;
         rd_col_reg     <= '0;
         issue_done_reg <= 1'b0;
         pend_valid_reg <= 1'b0;
         pend_ch_reg    <= '0;
         pend_row_reg   <= '0;
         pend_col_reg   <= '0;
         skid_valid_reg <= 1'b0;
         skid_data_reg  <= '0;
         skid_ch_reg    <= '0;
         skid_row_reg   <= '0;
         skid_col_reg   <= '0;
         out_valid_reg  <= 1'b0;
         out_data_reg   <= '0;
         out_ch_reg     <= '0;
         out_row_reg    <= '0;
         out_col_reg    <= '0;
         frame_done_reg <= 1'b0;
         overflow_reg   <= 1'b0;
      end else begin
         frame_done_reg <= frame_end;
         if ((state_reg == ST_DRAIN) && valid_in) overflow_reg <= 1'b1;

         if (wr_fire) begin
            if (wr_last) begin
               wr_row_reg <= '0;
               wr_col_reg <= '0;
            end else if (wr_col_reg == COL_LAST) begin
               wr_col_reg <= '0;
               wr_row_reg <= wr_row_reg + 1'b1;
            end else begin
               wr_col_reg <= wr_col_reg + 1'b1;
            end
         end

         // The read counters wrap to zero after the last issue, so only the
         // done flag needs clearing when the frame completes.
         if (frame_end) begin
            issue_done_reg <= 1'b0;
         end else if (issue) begin
            if (rd_col_reg == COL_LAST) begin
               rd_col_reg <= '0;
               if (rd_row_reg == ROW_LAST) begin
                  rd_row_reg <= '0;
                  if (rd_ch_reg == CH_LAST) begin
                     rd_ch_reg      <= '0;
                     issue_done_reg <= 1'b1;
                  end else begin
                     rd_ch_reg <= rd_ch_reg + 1'b1;
                  end
               end else begin
                  rd_row_reg <= rd_row_reg + 1'b1;
               end
            end else begin
               rd_col_reg <= rd_col_reg + 1'b1;
            end
         end

         pend_valid_reg <= issue;
         if (issue) begin
            pend_ch_reg  <= rd_ch_reg;
            pend_row_reg <= rd_row_reg;
            pend_col_reg <= rd_col_reg;
         end

         if (skid_valid_reg) skid_valid_reg <= load_out ? pend_valid_reg : 1'b1;
         else                skid_valid_reg <= pend_valid_reg && !load_out;
         if (skid_load) begin
            skid_data_reg <= pend_pix;
            skid_ch_reg   <= pend_ch_reg;
            skid_row_reg  <= pend_row_reg;
            skid_col_reg  <= pend_col_reg;
         end

         if (load_out) begin
            out_valid_reg <= skid_valid_reg || pend_valid_reg;
            if (skid_valid_reg) begin
               out_data_reg <= skid_data_reg;
               out_ch_reg   <= skid_ch_reg;
               out_row_reg  <= skid_row_reg;
               out_col_reg  <= skid_col_reg;
            end else if (pend_valid_reg) begin
               out_data_reg <= pend_pix;
               out_ch_reg   <= pend_ch_reg;
               out_row_reg  <= pend_row_reg;
               out_col_reg  <= pend_col_reg;
            end
         end
      end
   end

   assign data_out   = out_data_reg;
   assign valid_out  = out_valid_reg;
   assign ch_idx     = out_ch_reg;
   assign row_idx    = out_row_reg;
   assign col_idx    = out_col_reg;
   assign frame_done = frame_done_reg;
   assign overflow   = overflow_reg;

endmodule

// File: tb/tb_pool_fmap_buffer.sv
// ---------------------------------------------------------------------------
// tb_pool_fmap_buffer
// Directed self-checking bench for pool_fmap_buffer (12x12 map, 12-bit pixels).
// Expected drain values come from the pixels the bench itself wrote.
// ---------------------------------------------------------------------------
module tb_pool_fmap_buffer;

   localparam int CB    = 12;
   localparam int HW    = 12;
   localparam int HH    = 12;
   localparam int HWB   = 4;
   localparam int NPIX  = HW * HH;
   localparam int TOTAL = 3 * NPIX;

   logic           clk = 1'b0;
   logic           rst;
   logic           valid_in;
   logic [CB-1:0]  max_value_1, max_value_2, max_value_3;
   logic [CB-1:0]  data_out;
   logic           valid_out;
   logic           ready_in;
   logic [1:0]     ch_idx;
   logic [HWB-1:0] row_idx, col_idx;
   logic           frame_done;
   logic           overflow;

   int checks = 0;
   int errors = 0;
   int exp_pix [TOTAL];

   always #5 clk = ~clk;

   pool_fmap_buffer #(
      .CONV_BIT       (CB),
      .HALF_WIDTH     (HW),
      .HALF_HEIGHT    (HH),
      .HALF_WIDTH_BIT (HWB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .valid_in    (valid_in),
      .max_value_1 (max_value_1),
      .max_value_2 (max_value_2),
      .max_value_3 (max_value_3),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .ready_in    (ready_in),
      .ch_idx      (ch_idx),
      .row_idx     (row_idx),
      .col_idx     (col_idx),
      .frame_done  (frame_done),
      .overflow    (overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid_out"},  32'(valid_out), 32'd0);
      chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      chk({tag, "_overflow"},   32'(overflow), 32'd0);
      chk({tag, "_data_out"},   32'(data_out), 32'd0);
      chk({tag, "_idx"},        32'({ch_idx, row_idx, col_idx}), 32'd0);
   endtask

   // Writes pixels first..last; ready_in is toggled to show it has no effect.
   task automatic fill(input int b0, input int b1, input int b2, input int first, input int last);
      for (int a = first; a <= last; a++) begin
         valid_in    = 1'b1;
         max_value_1 = CB'(b0 + a);
         max_value_2 = CB'(b1 + a);
         max_value_3 = CB'(b2 + a);
         exp_pix[a]          = b0 + a;
         exp_pix[NPIX + a]   = b1 + a;
         exp_pix[2*NPIX + a] = b2 + a;
         ready_in = ($urandom_range(0, 1) != 0);
         @(posedge clk); #1;
         $display("wr addr=%0d ch0=%0d ch1=%0d ch2=%0d", a, b0 + a, b1 + a, b2 + a);
         if (a == first) chk("fill_frame_done_low", 32'(frame_done), 32'd0);
         chk("fill_valid_out_low", 32'(valid_out), 32'd0);
      end
      valid_in = 1'b0;
   endtask

   // Called one step after the edge that captured the last pixel.
   task automatic latency();
      @(posedge clk); #1;
      chk("latency_edge1_valid", 32'(valid_out), 32'd0);
      @(posedge clk); #1;
      chk("latency_edge2_valid", 32'(valid_out), 32'd1);
   endtask

   // mode 0: ready_in held high, mode 1: random ready_in.
   // n_ovf : valid_in pulses on the first n_ovf drain cycles.
   // ovf_last : valid_in also raised on the final transfer edge.
   task automatic drain(input int mode, input int n_ovf, input bit ovf_last, input int stop_at);
      int  k = 0;
      int  cyc = 0;
      int  ovf_left = n_ovf;
      bit  rdy, fire, stalled = 1'b0;
      int  exp_idx;
      logic [CB-1:0] seen;
      while (k < stop_at) begin
         if (cyc >= 4000) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout: observed=%0d transfers expected=%0d", k, stop_at);
            break;
         end
         if (stalled) chk("stall_valid_held", 32'(valid_out), 32'd1);
         if (valid_out) begin
            exp_idx = (k / NPIX) * 256 + ((k % NPIX) / HW) * 16 + (k % HW);
            chk("drain_data", 32'(data_out), 32'(exp_pix[k]));
            chk("drain_idx", 32'({ch_idx, row_idx, col_idx}), 32'(exp_idx));
         end
         chk("drain_frame_done_low", 32'(frame_done), 32'd0);
         rdy      = (mode == 0) ? 1'b1 : ($urandom_range(0, 1) != 0);
         ready_in = rdy;
         valid_in = 1'b0;
         if (ovf_left > 0) begin
            valid_in    = 1'b1;
            max_value_1 = CB'(4000 + ovf_left);
            max_value_2 = CB'(4010 + ovf_left);
            max_value_3 = CB'(4020 + ovf_left);
            ovf_left--;
         end
         fire = valid_out && rdy;
         if (ovf_last && fire && (k == TOTAL - 1)) begin
            valid_in    = 1'b1;
            max_value_1 = CB'(4095);
            max_value_2 = CB'(4095);
            max_value_3 = CB'(4095);
         end
         stalled = valid_out && !rdy;
         seen    = data_out;
         @(posedge clk); #1;
         cyc++;
         if (fire) begin
            $display("xfer k=%0d data=%0d", k, seen);
            k++;
         end
      end
      valid_in = 1'b0;
      if (k == TOTAL) begin
         chk("end_valid_out_low", 32'(valid_out), 32'd0);
         chk("end_frame_done_pulse", 32'(frame_done), 32'd1);
      end
   endtask

   initial begin
      rst         = 1'b1;
      valid_in    = 1'b0;
      ready_in    = 1'b0;
      max_value_1 = '0;
      max_value_2 = '0;
      max_value_3 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("por");
      rst = 1'b0;

      // Frame A: address-valued pixels, ready held high
      fill(0, 256, 512, 0, NPIX - 1);
      latency();
      drain(0, 0, 1'b0, TOTAL);
      chk("frameA_overflow_clear", 32'(overflow), 32'd0);
      @(posedge clk); #1;
      chk("frameA_frame_done_once", 32'(frame_done), 32'd0);
      chk("frameA_idle_valid", 32'(valid_out), 32'd0);

      // Frame B: 143 pixels only, then the last one; random stalls and overflow
      fill(1000, 2000, 3000, 0, NPIX - 2);
      for (int i = 0; i < 20; i++) begin
         ready_in = ($urandom_range(0, 1) != 0);
         @(posedge clk); #1;
         chk("partial_no_valid", 32'(valid_out), 32'd0);
      end
      fill(1000, 2000, 3000, NPIX - 1, NPIX - 1);
      latency();
      drain(1, 5, 1'b0, TOTAL);
      chk("frameB_overflow_set", 32'(overflow), 32'd1);

      // Frame C: first pixel in the cycle frame_done is high
      fill(100, 1100, 2100, 0, NPIX - 1);
      latency();
      drain(0, 0, 1'b0, TOTAL);
      chk("frameC_overflow_sticky", 32'(overflow), 32'd1);
      @(posedge clk); #1;
      chk("frameC_frame_done_once", 32'(frame_done), 32'd0);

      // Frame D: reset after 200 transfers, colliding with transfer and valid_in
      fill(7, 1007, 2007, 0, NPIX - 1);
      latency();
      drain(1, 0, 1'b0, 200);
      rst         = 1'b1;
      ready_in    = 1'b1;
      valid_in    = 1'b1;
      max_value_1 = CB'(4000);
      max_value_2 = CB'(4000);
      max_value_3 = CB'(4000);
      @(posedge clk); #1;
      chk_reset_outputs("mid_drain_rst");
      rst      = 1'b0;
      valid_in = 1'b0;

      // Frame E: fresh frame after reset, valid_in on the final transfer edge
      fill(50, 1050, 2050, 0, NPIX - 1);
      latency();
      chk("frameE_overflow_before", 32'(overflow), 32'd0);
      drain(0, 0, 1'b1, TOTAL);
      chk("frameE_overflow_last_edge", 32'(overflow), 32'd1);

      // Frame F: must still be aligned at address 0
      fill(300, 1300, 2300, 0, NPIX - 1);
      latency();
      drain(1, 0, 1'b0, TOTAL);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
